// File: rtl/pipe_stage_reg.sv
// Single-beat pipeline register (latency 1) with valid/ready handshake and flush; o_ready = i_ready || !o_valid.
// Define PIPE_STAGE_SKID_EN to add one skid entry so o_ready is driven purely from a flop.
module pipe_stage_reg #(
  parameter int                DATA_W    = 32,
  parameter int                PC_W      = 30,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_instr,
  input  logic [PC_W-1:0]   i_pc,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_instr,
  output logic [PC_W-1:0]   o_pc
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              accept;
  logic              out_free;

  // Output register can take a new beat when it is empty or draining this cycle.
  assign out_free = !valid_q || i_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_vld_q, skid_vld_d;
  logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]   skid_pc_q, skid_pc_d;

  assign o_ready = !skid_vld_q;
  assign accept  = i_valid && o_ready;

  always_comb begin
    valid_d      = valid_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    skid_vld_d   = skid_vld_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (i_flush) begin
      valid_d    = 1'b0;
      instr_d    = NOP_VALUE;
      skid_vld_d = 1'b0;
    end else if (out_free) begin
      // A full skid blocks acceptance, so at most one of these sources is live.
      if (skid_vld_q) begin
        valid_d    = 1'b1;
        instr_d    = skid_instr_q;
        pc_d       = skid_pc_q;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        valid_d = 1'b1;
        instr_d = i_instr;
        pc_d    = i_pc;
      end else begin
        valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_vld_d   = 1'b1;
      skid_instr_d = i_instr;
      skid_pc_d    = i_pc;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      skid_vld_q   <= 1'b0;
      skid_instr_q <= NOP_VALUE;
      skid_pc_q    <= '0;
    end else begin
      skid_vld_q   <= skid_vld_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end
`else
  assign o_ready = out_free;
  assign accept  = i_valid && o_ready;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (i_flush) begin
      valid_d = 1'b0;
      instr_d = NOP_VALUE;
    end else if (accept) begin
      valid_d = 1'b1;
      instr_d = i_instr;
      pc_d    = i_pc;
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      instr_q <= NOP_VALUE;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign o_valid = valid_q;
  assign o_instr = instr_q;
  assign o_pc    = pc_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: accepted beats are queued, delivered beats are popped and compared.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [31:0] instr;
    logic [29:0] pc;
  } beat_t;

  logic        clk = 1'b0;
  logic        i_rst, i_valid, i_flush, i_ready;
  logic        o_ready, o_valid;
  logic [31:0] i_instr, o_instr;
  logic [29:0] i_pc, o_pc;

  int    checks = 0;
  int    errors = 0;
  beat_t src[$];
  beat_t exp_q[$];
  beat_t got;
  beat_t want;
  bit    bubble_en = 1'b0;

  pipe_stage_reg dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_instr (i_instr),
    .i_pc    (i_pc),
    .i_flush (i_flush),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_instr (o_instr),
    .o_pc    (o_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic refresh();
    if (src.size() > 0 && (!bubble_en || $urandom_range(0, 3) != 0)) begin
      i_valid = 1'b1;
      i_instr = src[0].instr;
      i_pc    = src[0].pc;
    end else begin
      i_valid = 1'b0;
    end
  endtask

  // Advance one clock; upstream retires the presented beat when it was handshaken.
  task automatic step();
    bit hs;
    #1;
    hs = i_valid && o_ready;
    @(posedge clk);
    #1;
    if (hs && src.size() > 0) void'(src.pop_front());
    refresh();
  endtask

  task automatic push(input logic [31:0] instr, input logic [29:0] pc);
    beat_t b;
    b.instr = instr;
    b.pc    = pc;
    src.push_back(b);
  endtask

  // Monitor: sampled mid-cycle, so these values match what the next rising edge sees.
  always @(negedge clk) begin
    if (i_rst) begin
      exp_q.delete();
    end else begin
      if (o_valid && i_ready) begin
        checks++;
        got.instr = o_instr;
        got.pc    = o_pc;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat actual=%h expected=none", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL beat_order actual=%h expected=%h", got, want);
          end
        end
      end
      if (i_flush) exp_q.delete();
      else if (i_valid && o_ready) exp_q.push_back(beat_t'({i_instr, i_pc}));
    end
  end

  initial begin
    i_rst = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
    i_instr = '0; i_pc = '0;
    #2 i_rst = 1'b1;
    #1;
    chk("rst_valid", 64'(o_valid), 64'h0);
    chk("rst_instr", 64'(o_instr), 64'h0);
    chk("rst_pc",    64'(o_pc),    64'h0);
    step();
    step();
    i_rst = 1'b0;
    step();
    chk("rel_ready", 64'(o_ready), 64'h1);
    chk("rel_valid", 64'(o_valid), 64'h0);

    // Streaming with latency 1, then a 3-cycle stall on 0x22.
    push(32'h11, 30'd1); push(32'h22, 30'd2); push(32'h33, 30'd3);
    i_ready = 1'b1;
    refresh();
    step();
    chk("s11_valid", 64'(o_valid), 64'h1);
    chk("s11_instr", 64'(o_instr), 64'h11);
    chk("s11_pc",    64'(o_pc),    64'h1);
    step();
    chk("s22_valid", 64'(o_valid), 64'h1);
    chk("s22_instr", 64'(o_instr), 64'h22);
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_valid", 64'(o_valid), 64'h1);
      chk("stall_instr", 64'(o_instr), 64'h22);
      chk("stall_pc",    64'(o_pc),    64'h2);
`ifdef PIPE_STAGE_SKID_EN
      chk("stall_skid_ready", 64'(o_ready), 64'h0);
`endif
    end
    i_ready = 1'b1;
    step();
    chk("s33_valid", 64'(o_valid), 64'h1);
    chk("s33_instr", 64'(o_instr), 64'h33);

    // Flush while stalled with a second beat waiting (skid full in the skid build).
    push(32'h55, 30'd5); push(32'h66, 30'd6);
    refresh();
    step();
    chk("f55_instr", 64'(o_instr), 64'h55);
    i_ready = 1'b0;
    step();
    chk("f55_hold", 64'(o_instr), 64'h55);
    chk("f55_pc",   64'(o_pc),    64'h5);
    i_flush = 1'b1;
    src.delete();
    step();
    i_flush = 1'b0;
    chk("flush_valid", 64'(o_valid), 64'h0);
    chk("flush_instr", 64'(o_instr), 64'h0);
    chk("flush_pc",    64'(o_pc),    64'h5);
    chk("flush_ready", 64'(o_ready), 64'h1);
    i_ready = 1'b1;
    step();
    chk("flush_gone", 64'(o_valid), 64'h0);

    // Flush on the same edge that accepts 0x44.
    i_ready = 1'b0;
    push(32'h44, 30'd4);
    refresh();
    chk("f44_ready", 64'(o_ready), 64'h1);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    chk("f44_valid", 64'(o_valid), 64'h0);
    chk("f44_instr", 64'(o_instr), 64'h0);
    chk("f44_pc",    64'(o_pc),    64'h5);
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("f44_never", 64'(o_valid), 64'h0);
    end

    // Reset asserted with beats in flight.
    i_ready = 1'b0;
    push(32'h77, 30'd7); push(32'h88, 30'd8);
    refresh();
    step();
    step();
    chk("mid_instr", 64'(o_instr), 64'h77);
    #1 i_rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(o_valid), 64'h0);
    chk("mid_rst_instr", 64'(o_instr), 64'h0);
    chk("mid_rst_pc",    64'(o_pc),    64'h0);
    src.delete();
    i_valid = 1'b0;
    step();
    i_rst = 1'b0;
    step();
    chk("mid_rel_ready", 64'(o_ready), 64'h1);
    chk("mid_rel_valid", 64'(o_valid), 64'h0);

    // Random valid/ready traffic; the scoreboard checks every delivered beat.
    for (int n = 0; n < 150; n++) push($urandom, 30'($urandom));
    bubble_en = 1'b1;
    refresh();
    for (int c = 0; c < 600 && src.size() > 0; c++) begin
`ifdef PIPE_STAGE_SKID_EN
      begin
        logic r0;
        r0 = o_ready;
        i_ready = 1'($urandom_range(0, 1));
        #1;
        chk("ready_flop_only", 64'(o_ready), 64'(r0));
      end
`else
      i_ready = 1'($urandom_range(0, 1));
`endif
      step();
    end
    bubble_en = 1'b0;
    i_ready = 1'b1;
    refresh();
    for (int c = 0; c < 200 && (src.size() > 0 || exp_q.size() > 0 || o_valid); c++) step();
    chk("drain_empty", 64'(src.size() + exp_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
